// File: rtl/alu8_chk_pkg.sv
// alu8_chk_pkg: opcodes, queued-expectation entry, FSM states and the golden ALU model
// shared by the response checker.
package alu8_chk_pkg;

    localparam int ALU_DW = 8;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [2:0]        op;
        logic [ALU_DW-1:0] a;
        logic [ALU_DW-1:0] b;
        logic [ALU_DW-1:0] exp;
    } entry_t;

    // ADD/SUB wrap because the result is truncated to the datapath width.
    function automatic logic [ALU_DW-1:0] golden_f(input logic [2:0] op,
                                                   input logic [ALU_DW-1:0] a,
                                                   input logic [ALU_DW-1:0] b);
        case (op)
            OP_AND:  golden_f = a & b;
            OP_OR:   golden_f = a | b;
            OP_XOR:  golden_f = a ^ b;
            OP_ADD:  golden_f = a + b;
            OP_SUB:  golden_f = a - b;
            OP_NOT:  golden_f = ~a;
            OP_PASS: golden_f = a;
            OP_RSVD: golden_f = '0;
            default: golden_f = '0;
        endcase
    endfunction

endpackage

// File: rtl/alu8_resp_checker_if.sv
// alu8_resp_checker_if: stimulus request and DUT response signals seen by the checker.
interface alu8_resp_checker_if
    import alu8_chk_pkg::*;
#(
    parameter int DW = ALU_DW
);
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          rsp_valid;
    logic [DW-1:0] rsp_z;

    modport master (output req_valid, req_op, req_a, req_b, rsp_valid, rsp_z, input req_ready);
    modport slave  (input req_valid, req_op, req_a, req_b, rsp_valid, rsp_z, output req_ready);
endinterface

// File: rtl/alu8_chk_fifo.sv
// alu8_chk_fifo: synchronous FIFO with an extra pointer bit separating full from empty;
// the head entry is read combinationally.
module alu8_chk_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];

    assign empty = wptr_q == rptr_q;
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count = wptr_q - rptr_q;
    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(push && !full);
        rptr_d = rptr_q + (AW+1)'(pop && !empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
        if (push && !full) mem_q[wptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/alu8_resp_checker.sv
// alu8_resp_checker: queues golden ALU results and scores in-order DUT responses.
// Define ALU8_CHK_FIRSTFAIL_EN to capture the first failing transaction on the ff_* ports.
module alu8_resp_checker
    import alu8_chk_pkg::*;
#(
    parameter int DW           = ALU_DW,
    parameter int DEPTH        = 4,
    parameter int CW           = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    alu8_resp_checker_if.slave     bus,
    input  logic                   clr,
    output logic [CW-1:0]          pass_cnt,
    output logic [CW-1:0]          fail_cnt,
    output logic [CW-1:0]          orphan_cnt,
    output logic                   any_fail,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] pending,
    output logic [2:0]             ff_op,
    output logic [DW-1:0]          ff_a,
    output logic [DW-1:0]          ff_b,
    output logic [DW-1:0]          ff_exp,
    output logic [DW-1:0]          ff_got
);
    state_t        state_q, state_d;
    entry_t        wr_ent, head;
    logic          full, empty, push, pop, orphan, mism;
    logic [CW-1:0] pass_q, pass_d, fail_q, fail_d, orphan_q, orphan_d;
    logic          any_fail_q, any_fail_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return &c ? c : c + 1'b1;
    endfunction

    assign bus.req_ready = !full && state_q == RUN;
    assign push   = bus.req_valid && bus.req_ready;
    assign pop    = bus.rsp_valid && !empty;
    assign orphan = bus.rsp_valid && empty;
    assign mism   = pop && head.exp != bus.rsp_z;
    assign wr_ent = '{op: bus.req_op, a: bus.req_a, b: bus.req_b,
                      exp: golden_f(bus.req_op, bus.req_a, bus.req_b)};

    alu8_chk_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_ent),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (pending)
    );

    // clr takes priority over any same-cycle event; the FIFO itself still advances.
    always_comb begin
        pass_d     = clr ? '0 : (pop && !mism) ? sat_inc(pass_q) : pass_q;
        fail_d     = clr ? '0 : mism ? sat_inc(fail_q) : fail_q;
        orphan_d   = clr ? '0 : orphan ? sat_inc(orphan_q) : orphan_q;
        any_fail_d = clr ? 1'b0 : any_fail_q | mism | orphan;
        state_d    = clr ? RUN : (STOP_ON_FAIL && mism) ? HALT : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q     <= '0;
            fail_q     <= '0;
            orphan_q   <= '0;
            any_fail_q <= 1'b0;
            state_q    <= RUN;
        end else begin
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            orphan_q   <= orphan_d;
            any_fail_q <= any_fail_d;
            state_q    <= state_d;
        end
    end

    assign pass_cnt   = pass_q;
    assign fail_cnt   = fail_q;
    assign orphan_cnt = orphan_q;
    assign any_fail   = any_fail_q;
    assign halted     = state_q == HALT;

`ifdef ALU8_CHK_FIRSTFAIL_EN
    entry_t        ff_q, ff_d;
    logic [DW-1:0] got_q, got_d;
    logic          ff_vld_q, ff_vld_d;

    always_comb begin
        ff_vld_d = clr ? 1'b0 : ff_vld_q | mism;
        ff_d     = clr ? '0 : (mism && !ff_vld_q) ? head : ff_q;
        got_d    = clr ? '0 : (mism && !ff_vld_q) ? bus.rsp_z : got_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ff_vld_q <= 1'b0;
            ff_q     <= '0;
            got_q    <= '0;
        end else begin
            ff_vld_q <= ff_vld_d;
            ff_q     <= ff_d;
            got_q    <= got_d;
        end
    end

    assign ff_op  = ff_q.op;
    assign ff_a   = ff_q.a;
    assign ff_b   = ff_q.b;
    assign ff_exp = ff_q.exp;
    assign ff_got = got_q;
`else
    logic unused_head;
    assign unused_head = ^{head.op, head.a, head.b};
    assign {ff_op, ff_a, ff_b, ff_exp, ff_got} = '0;
`endif
endmodule

// File: tb/tb_alu8_resp_checker.sv
// tb_alu8_resp_checker: plays the ALU side of the stream against the checker, with a
// scoreboard of expected entries and a reference model of counters and status.
module tb_alu8_resp_checker;
    import alu8_chk_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [15:0] pass_cnt, fail_cnt, orphan_cnt;
    logic        any_fail, halted;
    logic [2:0]  pending;
    logic [2:0]  ff_op;
    logic [7:0]  ff_a, ff_b, ff_exp, ff_got;

    exp_t        sb_q[$];
    exp_t        m_ff;
    logic [7:0]  m_ff_got;
    bit          m_ff_vld, m_any, m_halt;
    int          m_pass, m_fail, m_orph;
    int          n_tests, n_fail;

    always #5 clk = ~clk;

    alu8_resp_checker_if #(.DW(8)) bus();

    alu8_resp_checker #(.DW(8), .DEPTH(DEPTH), .CW(16), .STOP_ON_FAIL(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr        (clr),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .orphan_cnt (orphan_cnt),
        .any_fail   (any_fail),
        .halted     (halted),
        .pending    (pending),
        .ff_op      (ff_op),
        .ff_a       (ff_a),
        .ff_b       (ff_b),
        .ff_exp     (ff_exp),
        .ff_got     (ff_got)
    );

    function automatic logic [7:0] model_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return a + b;
            3'd4: return a - b;
            3'd5: return ~a;
            3'd6: return a;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_pass = 0;
        m_fail = 0;
        m_orph = 0;
        m_any = 1'b0;
        m_halt = 1'b0;
        m_ff_vld = 1'b0;
        m_ff = '{3'd0, 8'd0, 8'd0, 8'd0};
        m_ff_got = 8'd0;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_op = 3'd0;
        bus.req_a = 8'd0;
        bus.req_b = 8'd0;
        bus.rsp_valid = 1'b0;
        bus.rsp_z = 8'd0;
        clr = 1'b0;
    endtask

    // One clock of stimulus, called at a falling edge; returns at the next falling edge.
    task automatic step(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic rv, input logic [7:0] z, input logic c);
        exp_t h;
        bit   ready_m;
        ready_m = (sb_q.size() < DEPTH) && !m_halt;
        check("req_ready", bus.req_ready, ready_m);
        bus.req_valid = v;
        bus.req_op = op;
        bus.req_a = a;
        bus.req_b = b;
        bus.rsp_valid = rv;
        bus.rsp_z = z;
        clr = c;
        if (rv) begin
            if (sb_q.size() == 0) begin
                if (!c) begin
                    m_orph++;
                    m_any = 1'b1;
                end
            end else begin
                h = sb_q.pop_front();
                if (!c && h.exp == z) m_pass++;
                else if (!c) begin
                    m_fail++;
                    m_any = 1'b1;
                    m_halt = 1'b1;
                    if (!m_ff_vld) begin
                        m_ff_vld = 1'b1;
                        m_ff = h;
                        m_ff_got = z;
                    end
                end
            end
        end
        if (c) model_clear();
        if (v && ready_m) sb_q.push_back('{op, a, b, model_alu(op, a, b)});
        @(negedge clk);
        idle();
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pass"}, pass_cnt, m_pass);
        check({tag, ".fail"}, fail_cnt, m_fail);
        check({tag, ".orphan"}, orphan_cnt, m_orph);
        check({tag, ".any_fail"}, any_fail, m_any);
        check({tag, ".halted"}, halted, m_halt);
        check({tag, ".pending"}, pending, sb_q.size());
`ifdef ALU8_CHK_FIRSTFAIL_EN
        check({tag, ".ff_op"}, ff_op, m_ff.op);
        check({tag, ".ff_a"}, ff_a, m_ff.a);
        check({tag, ".ff_b"}, ff_b, m_ff.b);
        check({tag, ".ff_exp"}, ff_exp, m_ff.exp);
        check({tag, ".ff_got"}, ff_got, m_ff_got);
`else
        check({tag, ".ff_all"}, {ff_op, ff_a, ff_b, ff_exp, ff_got}, 0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        model_clear();
    endtask

    initial begin
        logic [7:0] z;
        n_tests = 0;
        n_fail = 0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        do_reset();
        check_all("reset");
        check("reset.ready", bus.req_ready, 1'b1);

        step(1, OP_AND, 8'h12, 8'h45, 0, 8'h00, 0);
        step(0, 0, 0, 0, 1, 8'h00, 0);
        check_all("and1");
        check("and1.pass_const", pass_cnt, 1);
        step(1, OP_AND, 8'h16, 8'h55, 0, 8'h00, 0);
        step(0, 0, 0, 0, 1, 8'h14, 0);
        check_all("and2");

        step(1, OP_ADD, 8'hFF, 8'h01, 0, 8'h00, 0);
        step(1, OP_SUB, 8'h00, 8'h01, 1, 8'h00, 0);
        step(0, 0, 0, 0, 1, 8'hFF, 0);
        check_all("wrap");
        check("wrap.pass_const", pass_cnt, 4);
        step(1, OP_RSVD, 8'hAB, 8'hCD, 0, 8'h00, 0);
        step(1, OP_NOT, 8'h0F, 8'h77, 1, 8'h00, 0);
        step(1, OP_PASS, 8'h5A, 8'h33, 1, 8'hF0, 0);
        step(0, 0, 0, 0, 1, 8'h5A, 0);
        check_all("rsvd_not_pass");

        step(1, OP_AND, 8'h92, 8'h47, 0, 8'h00, 0);
        step(0, 0, 0, 0, 1, 8'h03, 0);
        check_all("mism");
        check("mism.halted_const", halted, 1'b1);
        check("mism.ready", bus.req_ready, 1'b0);
`ifdef ALU8_CHK_FIRSTFAIL_EN
        check("mism.ff_exp_const", ff_exp, 8'h02);
        check("mism.ff_got_const", ff_got, 8'h03);
`endif
        step(1, OP_XOR, 8'h01, 8'h02, 0, 8'h00, 1);
        check_all("clr");

        for (int i = 0; i < 4; i++) step(1, 3'(i), 8'(i * 37), 8'(i * 91), 0, 8'h00, 0);
        check_all("full");
        check("full.ready", bus.req_ready, 1'b0);
        step(1, OP_ADD, 8'h80, 8'h80, 0, 8'h00, 0);
        check_all("held");
        z = sb_q[0].exp;
        step(1, OP_ADD, 8'h80, 8'h80, 1, z, 0);
        check_all("pop_full");
        step(1, OP_ADD, 8'h80, 8'h80, 0, 8'h00, 0);
        check_all("fifth");
        for (int i = 0; i < 4; i++) begin
            z = sb_q[0].exp;
            step(0, 0, 0, 0, 1, z, 0);
        end
        check_all("drain");

        step(1, OP_OR, 8'h30, 8'h03, 1, 8'h33, 0);
        check_all("orphan");
        z = sb_q[0].exp;
        step(1, OP_SUB, 8'h10, 8'h20, 1, z, 0);
        step(1, OP_XOR, 8'hFF, 8'h0F, 0, 8'h00, 0);
        step(1, OP_OR, 8'h01, 8'h80, 0, 8'h00, 0);
        check_all("pre_rst");
        do_reset();
        check_all("mid_rst");
        step(0, 0, 0, 0, 1, 8'h00, 0);
        check_all("post_rst_orphan");

        for (int i = 0; i < 80; i++) begin
            logic rv;
            if (m_halt) step(0, 0, 0, 0, 0, 8'h00, 1);
            else begin
                rv = 1'($urandom_range(0, 1));
                z = 8'($urandom);
                if (sb_q.size() != 0 && $urandom_range(0, 5) != 0) z = sb_q[0].exp;
                step(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom), rv, z, 0);
            end
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu8_resp_checker.md
Name: alu8_resp_checker

Overview:
- Synthesizable response checker for the 8-bit ALU datapath. It is the consuming end of the ALU stimulus stream.
- Accepts operand transactions (op, a, b) and computes the golden result. It queues the golden results in order and compares each against the DUT result when that result arrives, with arbitrary latency.
- Maintains pass/fail/orphan counters and sticky status. Sits beside the ALU in self-checking simulation and FPGA bring-up builds.

Parameters:
- DW, 8, operand and result width.
- DEPTH, 4, expected-result FIFO entries (power of 2, at least 2).
- CW, 16, width of each counter.
- STOP_ON_FAIL, 0, when 1 the first mismatch moves the FSM to HALT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  stimulus transaction valid.
- req_ready  out  1  checker can accept a stimulus transaction.
- req_op  in  3  opcode: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 NOT a, 6 PASS a, 7 reserved.
- req_a  in  DW  operand a.
- req_b  in  DW  operand b.
- rsp_valid  in  1  DUT result valid (no backpressure).
- rsp_z  in  DW  DUT result.
- clr  in  1  synchronous clear of counters and sticky flags.
- pass_cnt  out  CW  matched responses.
- fail_cnt  out  CW  mismatched responses.
- orphan_cnt  out  CW  responses received with the FIFO empty.
- any_fail  out  1  sticky; set on any mismatch or orphan.
- halted  out  1  FSM is in HALT.
- pending  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ff_op  out  3  first-failure opcode (optional feature).
- ff_a  out  DW  first-failure operand a (optional feature).
- ff_b  out  DW  first-failure operand b (optional feature).
- ff_exp  out  DW  first-failure expected result (optional feature).
- ff_got  out  DW  first-failure received result (optional feature).

Behaviour:
- Reset: all outputs are 0 except req_ready, which is 1 after the reset cycle. FIFO is emptied and the FSM goes to RUN. Reset mid-operation discards all queued expectations.
- Golden result:
  - Computed combinationally at accept and truncated to DW bits.
  - ADD and SUB wrap mod 2^DW; carry and borrow are dropped.
  - NOT and PASS ignore b.
  - Opcode 7 stores expected = 0 and is still checked.
- Accept: when req_valid and req_ready are both high, push {op, a, b, exp}. req_ready = !full && state==RUN. req_ready depends only on registered state, never on req_valid.
- Response handling, one response per rsp_valid cycle:
  - FIFO non-empty: pop the head and compare with rsp_z. Equal increments pass_cnt; unequal increments fail_cnt and sets any_fail.
  - FIFO empty: increment orphan_cnt and set any_fail. No bypass: a push in the same cycle does not satisfy this response.
  - Counters update on the cycle after rsp_valid (latency 1).
- Simultaneous push and pop:
  - Non-empty, non-full FIFO: both happen and occupancy is unchanged.
  - Full FIFO: req_ready is 0, so only the pop happens.
- Pointers wrap mod DEPTH. A full/empty extra bit on the pointers distinguishes full from empty.
- Counters saturate at 2^CW-1 and do not wrap.
- clr zeroes the counters, any_fail, and the ff_* registers, and returns HALT to RUN. The FIFO contents are kept. When clr coincides with an event in the same cycle, clr wins and the event is not counted.
- FSM:
  - RUN to HALT on a mismatch when STOP_ON_FAIL=1.
  - HALT to RUN on clr.
  - In HALT, req_ready=0; responses are still compared and counted.
  - Orphans never cause HALT.

Optional Feature:
- Macro ALU8_CHK_FIRSTFAIL_EN.
- Defined: on the first mismatch since reset or clr, latch ff_op, ff_a, ff_b, ff_exp, ff_got from the popped entry and rsp_z. Later failures do not overwrite these registers.
- Undefined: the ff_* ports are tied to 0 and no capture registers exist.

Decomposition:
- Package alu8_chk_pkg holds:
  - opcode localparams OP_AND through OP_RSVD;
  - the entry struct {op, a, b, exp};
  - a golden_f function (op, a, b) returning a DW-bit result.
- One sub-module, alu8_chk_fifo: synchronous FIFO with parameters DEPTH and width, outputs full/empty/count, no output register.

Test Plan:
- AND 0x12&0x45, DUT returns 0x00 after 1 cycle -> pass_cnt=1, any_fail=0. Then AND 0x16&0x55 with rsp 0x14 -> pass_cnt=2.
- ADD 0xFF+0x01 with rsp 0x00, then SUB 0x00-0x01 with rsp 0xFF -> both pass, showing wrap.
- AND 0x92&0x47 with rsp 0x03 (expected 0x02), STOP_ON_FAIL=1 -> fail_cnt=1, halted=1, req_ready=0. With the feature enabled, ff_exp=0x02 and ff_got=0x03. Then clr -> all counters 0 and halted=0.
- Push 4 requests with no responses -> pending=4, req_ready=0. A 5th req_valid is held. One rsp -> pending=3 and the 5th request is accepted on the next cycle.
- rsp_valid with the FIFO empty and req_valid in the same cycle -> orphan_cnt=1, any_fail=1, pending=1.
- 3 requests queued, then rst for 1 cycle -> pending=0 and all counters 0. A following rsp_valid counts as an orphan.
